otter_fetch_queue: RTL

// Instruction prefetch stage sitting directly upstream of the OTTER IF/DE pipeline register.
// - Owns the fetch PC and issues word reads on the instruction port (MEM_ADDR1/MEM_DOUT1) of Memory.
// - Buffers returned instructions with their PC in a small FIFO.
// - Hands them to decode through a valid/ready handshake.
// - Branch/jump redirects from the execute stage flush the queue and any in-flight read.

---
 rtl/otter_fetch_queue.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/otter_fetch_queue.sv
// ============================================================================
// otter_fetch_queue
// ----------------------------------------------------------------------------
// Instruction prefetch stage in front of the OTTER IF/DE pipeline register.
// It owns the fetch PC, issues one word read per cycle on the instruction
// port of Memory (1-cycle synchronous read), buffers the returned words
// together with their PC in a small circular queue, and hands the head
// entry to decode over a valid/ready handshake. A redirect from execute
// (taken branch/jump) flushes the queue and drops any read still in flight.
//
// Parameters
//   DEPTH     queue entries; power of 2, >= 2
//   RESET_PC  fetch PC loaded by reset
//
// Ports
//   CLK          in   1   clock, all state changes on the rising edge
//   RST          in   1   synchronous active-high reset
//   FETCH_REQ    out  1   read issued this cycle on the instruction port
//   FETCH_ADDR   out  32  byte address of the read, word aligned
//   FETCH_DATA   in   32  instruction word, valid the cycle after FETCH_REQ
//   REDIRECT     in   1   flush queue and restart fetch at REDIRECT_PC
//   REDIRECT_PC  in   32  new fetch target, low two bits ignored
//   OUT_VALID    out  1   head entry valid
//   OUT_READY    in   1   decode accepts the head entry
//   OUT_IR       out  32  head instruction, NOP (0x13) when empty
//   OUT_PC       out  32  head PC, 0 when empty
//   OUT_PC_INC   out  32  head PC + 4, 0 when empty
//   COUNT        out  $clog2(DEPTH)+1  current queue occupancy
//
// Optional build macro
//   FETCH_QUEUE_PERF_EN  adds saturating 16-bit performance counters
//     FLUSH_CNT  out 16  cycles with REDIRECT asserted
//     EMPTY_CNT  out 16  cycles where decode was ready but the queue empty
// ============================================================================

module otter_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    CLK,
    input  logic                    RST,
    output logic                    FETCH_REQ,
    output logic [31:0]             FETCH_ADDR,
    input  logic [31:0]             FETCH_DATA,
    input  logic                    REDIRECT,
    input  logic [31:0]             REDIRECT_PC,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [31:0]             OUT_IR,
    output logic [31:0]             OUT_PC,
    output logic [31:0]             OUT_PC_INC,
    output logic [$clog2(DEPTH):0]  COUNT
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [15:0]             FLUSH_CNT,
    output logic [15:0]             EMPTY_CNT
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    // One more bit than COUNT so count + inflight never wraps.
    localparam int unsigned OCC_W = CNT_W + 1;

    localparam logic [31:0]      NOP_IR    = 32'h0000_0013;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } entry_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    entry_t           queue_mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count_q;

    logic [31:0]      fetch_pc;
    logic             inflight;      // a read was issued last cycle
    logic [31:0]      inflight_pc;   // PC of that read

    // ------------------------------------------------------------------
    // Handshake / issue decode
    // ------------------------------------------------------------------
    logic             pop;
    logic             push;
    logic             issue;
    logic [OCC_W-1:0] occ_after_pop;
    logic [31:0]      redirect_target;
    entry_t           head_entry;

    // NOTE: every signal driven in an always_comb gets a default on the first
    // lines of the block, so no path can leave it unassigned and infer a latch.
    always_comb begin
        pop             = 1'b0;
        push            = 1'b0;
        issue           = 1'b0;
        occ_after_pop   = '0;
        redirect_target = REDIRECT_PC & ~32'h0000_0003;

        pop = OUT_VALID & OUT_READY;

        // Returned word is only kept when nothing is flushing this cycle.
        push = inflight & ~REDIRECT & ~RST;

        // Slots already claimed: stored entries plus the read in flight,
        // minus the entry decode takes this cycle. Issuing only when this
        // is below DEPTH means the push one cycle later always has room,
        // while a pop in the same cycle keeps a full queue streaming.
        occ_after_pop = {1'b0, count_q} + OCC_W'(inflight) - OCC_W'(pop);
        issue         = ~RST & ~REDIRECT & (occ_after_pop < DEPTH_OCC);
    end

    assign head_entry = queue_mem[head_ptr];

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign FETCH_REQ  = issue;
    assign FETCH_ADDR = fetch_pc;
    assign COUNT      = count_q;
    assign OUT_VALID  = (count_q != '0);
    assign OUT_IR     = OUT_VALID ? head_entry.ir        : NOP_IR;
    assign OUT_PC     = OUT_VALID ? head_entry.pc        : 32'h0;
    assign OUT_PC_INC = OUT_VALID ? head_entry.pc + 32'd4 : 32'h0;

    // ------------------------------------------------------------------
    // Queue storage
    // ------------------------------------------------------------------
    // NOTE: the entry array has no reset; validity is carried by count and
    // the pointers, so leaving it out lets the array map onto plain storage.
    always_ff @(posedge CLK) begin
        if (push) begin
            queue_mem[tail_ptr] <= '{pc: inflight_pc, ir: FETCH_DATA};
        end
    end

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count_q  <= '0;
        end else if (REDIRECT) begin
            // Flush wins over any push or pop in the same cycle.
            head_ptr <= '0;
            tail_ptr <= '0;
            count_q  <= '0;
        end else begin
            if (pop) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            if (push) begin
                tail_ptr <= tail_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Fetch PC and in-flight read tracking
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
        end else if (REDIRECT) begin
            // The read returning next cycle belongs to the old stream.
            fetch_pc    <= redirect_target;
            inflight    <= 1'b0;
            inflight_pc <= inflight_pc;
        end else if (issue) begin
            fetch_pc    <= fetch_pc + 32'd4;   // wraps past 0xFFFF_FFFC
            inflight    <= 1'b1;
            inflight_pc <= fetch_pc;
        end else begin
            inflight    <= 1'b0;
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters, saturating at all ones
    // ------------------------------------------------------------------
    logic [15:0] flush_cnt;
    logic [15:0] empty_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            flush_cnt <= '0;
            empty_cnt <= '0;
        end else begin
            if (REDIRECT && (flush_cnt != 16'hFFFF)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
            if (!OUT_VALID && OUT_READY && (empty_cnt != 16'hFFFF)) begin
                empty_cnt <= empty_cnt + 16'd1;
            end
        end
    end

    assign FLUSH_CNT = flush_cnt;
    assign EMPTY_CNT = empty_cnt;
`endif

endmodule
